// File: rtl/nim_pkg.sv
// Shared types and defaults for the NIM coincidence trigger.
//   state_e       : trigger FSM states (Idle, Fire, Dead)
//   N_CH_DEF      : default channel count
//   CNT_W_DEF     : default event counter width
//   count_ones()  : population count of a 16-bit vector
package nim_pkg;

  localparam int unsigned N_CH_DEF  = 8;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Fire = 2'd1,
    Dead = 2'd2
  } state_e;

  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nim_coincidence_if.sv
// Bus bundle for nim_coincidence.
//   master : drives trigger levels, configuration, veto/enable/reset_cnt; observes results
//   slave  : the coincidence block itself
interface nim_coincidence_if import nim_pkg::*; #(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic [N_CH-1:0]  trig_in;
  logic [N_CH-1:0]  coinc_mask;
  logic [4:0]       min_mult;
  logic [15:0]      prescale;
  logic [7:0]       out_width;
  logic [15:0]      deadtime;
  logic             veto_in;
  logic             enable;
  logic             reset_cnt;
  logic             trig_out;
  logic             busy;
  logic [CNT_W-1:0] raw_count;
  logic [CNT_W-1:0] accepted_count;
  logic [CNT_W-1:0] vetoed_count;

  modport master (
    output trig_in, coinc_mask, min_mult, prescale, out_width, deadtime,
           veto_in, enable, reset_cnt,
    input  trig_out, busy, raw_count, accepted_count, vetoed_count
  );

  modport slave (
    input  trig_in, coinc_mask, min_mult, prescale, out_width, deadtime,
           veto_in, enable, reset_cnt,
    output trig_out, busy, raw_count, accepted_count, vetoed_count
  );

endinterface

// File: rtl/nim_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous clear, wins over inc
//   inc          : count one event; holds at all-ones
//   count        : current value
module nim_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nim_coincidence.sv
// Multiplicity coincidence trigger with prescaler, fixed-width output pulse and deadtime.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : trig_in/coinc_mask/min_mult select coincidences; prescale, out_width,
//                  deadtime, veto_in, enable, reset_cnt control acceptance; trig_out, busy
//                  and raw/accepted/vetoed counters report.
// Build option: define NIM_COINC_VETO_EN to implement veto_in and vetoed_count; otherwise
// veto_in is ignored and vetoed_count stays 0.
module nim_coincidence import nim_pkg::*; #(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic              clk,
  input logic              reset_n,
  nim_coincidence_if.slave bus
);

  // Registered configuration
  logic [N_CH-1:0] mask_q;
  logic [4:0]      min_mult_q;
  logic [15:0]     prescale_q;
  logic [7:0]      out_width_q;
  logic [15:0]     deadtime_q;
  logic            enable_q;

  // Coincidence pipeline: S1 sample -> cond -> candidate
  logic [N_CH-1:0] trig_s1_q;
  logic            s1_valid_q, cond_valid_q, arm_q;
  logic            cond_q, cond_prev_q, cand_q;
  logic [15:0]     hits;
  logic [4:0]      hit_cnt;
  logic            cond;
  logic            veto;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] fire_len;
  logic        presc_match, fire_entry, eligible, vetoed_inc;

  assign hits    = 16'(trig_s1_q & mask_q);
  assign hit_cnt = count_ones(hits);
  assign cond    = (min_mult_q != 5'd0) && (hit_cnt >= min_mult_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q       <= '0;
      min_mult_q   <= '0;
      prescale_q   <= '0;
      out_width_q  <= '0;
      deadtime_q   <= '0;
      enable_q     <= 1'b0;
      trig_s1_q    <= '0;
      s1_valid_q   <= 1'b0;
      cond_valid_q <= 1'b0;
      arm_q        <= 1'b0;
      cond_q       <= 1'b0;
      cond_prev_q  <= 1'b0;
      cand_q       <= 1'b0;
    end else begin
      mask_q       <= bus.coinc_mask;
      min_mult_q   <= bus.min_mult;
      prescale_q   <= bus.prescale;
      out_width_q  <= bus.out_width;
      deadtime_q   <= bus.deadtime;
      enable_q     <= bus.enable;
      trig_s1_q    <= bus.trig_in;
      s1_valid_q   <= 1'b1;
      cond_valid_q <= s1_valid_q;
      cond_q       <= cond;
      cond_prev_q  <= cond_q;
      // Arm only after cond is seen low from a real sample, so a level already high
      // when reset is released never counts as a rising edge.
      arm_q        <= arm_q | (cond_valid_q & ~cond_q);
      cand_q       <= cond_q & ~cond_prev_q & arm_q;
    end
  end

`ifdef NIM_COINC_VETO_EN
  // Veto travels alongside the trigger sample so it lines up with cand_q.
  logic veto_s1_q, veto_s2_q, veto_s3_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      veto_s1_q <= 1'b0;
      veto_s2_q <= 1'b0;
      veto_s3_q <= 1'b0;
    end else begin
      veto_s1_q <= bus.veto_in;
      veto_s2_q <= veto_s1_q;
      veto_s3_q <= veto_s2_q;
    end
  end
  assign veto = veto_s3_q;
`else
  logic unused_veto;
  assign unused_veto = bus.veto_in;
  assign veto        = 1'b0;
`endif

  assign eligible   = (state_q == Idle) && cand_q && enable_q && !veto;
  assign vetoed_inc = (state_q == Idle) && cand_q && veto;
  assign fire_len   = (out_width_q == 8'd0) ? 16'd1 : {8'd0, out_width_q};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    presc_d     = presc_q;
    presc_match = 1'b0;
    fire_entry  = 1'b0;

    // Prescaler at 0 reloads without accepting (unless prescale is 0), then counts
    // down; the candidate that brings it from 1 to 0 is the accepted one.
    if (eligible) begin
      if (presc_q == 16'd0) begin
        presc_d     = prescale_q;
        presc_match = (prescale_q == 16'd0);
      end else begin
        presc_d     = presc_q - 16'd1;
        presc_match = (presc_q == 16'd1);
      end
    end
    if (bus.reset_cnt) begin
      presc_d = '0;
    end

    if (!enable_q) begin
      state_d = Idle;
      timer_d = '0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (eligible && presc_match) begin
            state_d    = Fire;
            timer_d    = fire_len - 16'd1;
            fire_entry = 1'b1;
          end
        end
        Fire: begin
          if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
          end else if (deadtime_q == 16'd0) begin
            state_d = Idle;
          end else begin
            state_d = Dead;
            timer_d = deadtime_q - 16'd1;
          end
        end
        Dead: begin
          if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
          end else begin
            state_d = Idle;
          end
        end
        default: begin
          state_d = Idle;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Idle;
      timer_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
    end
  end

  assign bus.trig_out = (state_q == Fire);
  assign bus.busy     = (state_q != Idle);

  nim_sat_counter #(.W(CNT_W)) u_raw_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.reset_cnt),
    .inc     (cand_q),
    .count   (bus.raw_count)
  );

  nim_sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.reset_cnt),
    .inc     (fire_entry),
    .count   (bus.accepted_count)
  );

  nim_sat_counter #(.W(CNT_W)) u_veto_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.reset_cnt),
    .inc     (vetoed_inc),
    .count   (bus.vetoed_count)
  );

endmodule

// File: doc/nim_coincidence.md
NIM_COINCIDENCE -- requirements
Module: nim_coincidence

Interface
REQ-001 Parameter N_CH, default 8: number of conditioned NIM channels consumed (2..16).
REQ-002 Parameter CNT_W, default 32: width of every event counter.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 trig_in  input  N_CH  per-channel conditioned trigger levels from upstream NIM_input trig_out.
REQ-006 coinc_mask  input  N_CH  1 = channel participates in multiplicity.
REQ-007 min_mult  input  5  required multiplicity; 0 = never fire.
REQ-008 prescale  input  16  accept one of every prescale+1 eligible candidates.
REQ-009 out_width  input  8  trig_out pulse length in cycles; 0 treated as 1.
REQ-010 deadtime  input  16  cycles held busy after the pulse ends.
REQ-011 veto_in  input  1  external veto level.
REQ-012 enable  input  1  arms the block.
REQ-013 reset_cnt  input  1  synchronous clear of counters and the prescaler.
REQ-014 trig_out  output  1  accepted trigger pulse.
REQ-015 busy  output  1  high in FIRE or DEAD.
REQ-016 raw_count, accepted_count, vetoed_count  output  CNT_W each  event counters.

Function
REQ-017 All config inputs (coinc_mask..deadtime, enable) SHALL be registered once before use.
REQ-018 trig_in and veto_in SHALL be registered once (stage S1); cond = popcount(trig_S1 & coinc_mask) >= min_mult, with min_mult 0 forcing cond=0.
REQ-019 Candidate SHALL be a rising edge of cond (cond & ~cond_prev); a level held high yields exactly one candidate.
REQ-020 FSM states IDLE, FIRE, DEAD; FIRE lasts max(out_width,1) cycles; DEAD lasts deadtime cycles; deadtime 0 goes FIRE->IDLE directly.
REQ-021 A candidate in IDLE with enable=1 and veto_S1=0 SHALL advance the prescaler; on prescaler match it enters FIRE, otherwise it stays in IDLE.
REQ-022 Latency: trig_out SHALL rise on the 3rd rising edge after the edge that first samples the coincident trig_in.
REQ-023 trig_out=1 exactly while in FIRE; busy=1 in FIRE or DEAD.
REQ-024 Candidates in FIRE/DEAD SHALL count in raw_count only; they are not queued.
REQ-025 raw_count +1 per candidate; accepted_count +1 per FIRE entry; vetoed_count +1 per candidate in IDLE with veto_S1=1; the prescaler does not advance on a vetoed candidate.
REQ-026 Counters SHALL saturate at all-ones, not wrap.
REQ-027 reset_cnt SHALL clear all counters and the prescaler next cycle; it does not affect FSM state; reset_cnt wins over a simultaneous increment.
REQ-028 enable_z deasserting SHALL force IDLE next cycle, terminating FIRE/DEAD; raw_count still counts.
REQ-029 The prescaler SHALL be a 16-bit down-counter reloaded from prescale on match; prescale 0 accepts every eligible candidate.

Reset
REQ-030 reset_n low SHALL set FSM=IDLE, trig_out=0, busy=0, all counters=0, prescaler=0, and all pipeline/config registers=0, immediately and asynchronously.
REQ-031 Deassertion mid-pulse SHALL NOT resume the pulse; the first candidate after reset requires a fresh rising edge of cond.

Configuration
REQ-032 Macro NIM_COINC_VETO_EN: when defined, veto logic and vetoed_count are implemented per REQ-021/025.
REQ-033 Without NIM_COINC_VETO_EN: ports are retained, veto_in is ignored, and vetoed_count is constant 0.

Structure
REQ-034 Package nim_pkg SHALL hold the state enum (IDLE/FIRE/DEAD) and the default constants N_CH_DEF=8 and CNT_W_DEF=32.
REQ-035 A single sub-module nim_sat_counter (width-parameterised saturating counter with clear and inc) SHALL be instantiated three times.

Verification
REQ-036 mask=0x03, min_mult=2, ch0/ch1 high together 5 cycles -> one trig_out of out_width=4 cycles 3 edges later; raw=1, accepted=1.
REQ-037 prescale=2, 6 separated candidates -> accepted_count=2 (3rd and 6th); raw_count=6.
REQ-038 deadtime=10, second candidate 5 cycles after the pulse ends -> no second pulse; raw=2, accepted=1, busy high for 4+10 cycles.
REQ-039 veto_in high during a candidate (VETO_EN) -> no pulse, vetoed=1, prescaler unchanged; without VETO_EN -> pulse, vetoed=0.
REQ-040 reset_n pulled low mid-FIRE -> trig_out 0 without a clock edge; counters 0; cond held high after release -> no pulse.
REQ-041 Counter preloaded near max via CNT_W=4, 20 candidates -> raw_count holds 15; reset_cnt with a simultaneous candidate -> 0.
